// File: rtl/fetch_unit.sv
// Fetch stage: IDLE/RUN/DONE sequencer with a one-word decode register and absolute branches.
// Optional macro INSTR_COUNT_EN adds a saturating 16-bit count of valid decode cycles (instr_count).
module fetch_unit #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 9
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               start,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic               instr_valid,
   input  logic               Branch,
   input  logic [1:0]         MUX7,
   input  logic               zero,
   input  logic [PC_W-1:0]    target,
   output logic [PC_W-1:0]    pc,
   output logic               done
`ifdef INSTR_COUNT_EN
   ,
   output logic [15:0]        instr_count
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [PC_W-1:0]      decode_pc_q, decode_pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 valid_q, valid_d;
   logic                 done_q, done_d;
   logic                 taken_s;
   logic                 halt_s;

   // A branch only counts when the word in decode is real; a jump onto itself halts.
   always_comb begin
      taken_s = Branch & valid_q &
                (((MUX7 == 2'd0) & zero) | ((MUX7 == 2'd1) & ~zero) | (MUX7 == 2'd2));
      halt_s  = taken_s & (MUX7 == 2'd2) & (target == decode_pc_q);
   end

   // Next-state and datapath updates for the sequencer.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      decode_pc_d = decode_pc_q;
      instr_d     = instr_q;
      valid_d     = 1'b0;
      done_d      = done_q;
      case (state_q)
         IDLE: begin
            pc_d   = {PC_W{1'b0}};
            done_d = 1'b0;
            if (start) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (halt_s) begin
               // pc and the halting word stay frozen for inspection.
               state_d = DONE;
               done_d  = 1'b1;
            end else if (taken_s) begin
               pc_d        = target;
               instr_d     = imem_data;
               decode_pc_d = pc_q;
            end else begin
               pc_d        = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
               instr_d     = imem_data;
               decode_pc_d = pc_q;
               valid_d     = 1'b1;
            end
         end
         DONE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = {PC_W{1'b0}};
               done_d  = 1'b0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = {PC_W{1'b0}};
            done_d  = 1'b0;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= IDLE;
         pc_q        <= {PC_W{1'b0}};
         decode_pc_q <= {PC_W{1'b0}};
         instr_q     <= {INSTR_W{1'b0}};
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         decode_pc_q <= decode_pc_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
      end
   end

   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[INSTR_W-1 -: 4];
   assign instr_valid = valid_q;
   assign done        = done_q;

`ifdef INSTR_COUNT_EN
   logic [15:0] count_q, count_d;

   // Count valid decode cycles; a start leaving IDLE/DONE clears the count.
   always_comb begin
      count_d = count_q;
      if (start & (state_q != RUN)) begin
         count_d = 16'h0000;
      end else if (valid_q & (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'h0001;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge CLK) begin
      if (reset) begin
         count_q <= 16'h0000;
      end else begin
         count_q <= count_d;
      end
   end

   assign instr_count = count_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter and instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 9, instruction width; opcode = instr[INSTR_W-1:INSTR_W-4].
REQ-003 SHALL have port CLK  in  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  pulse that begins program execution from address 0.
REQ-006 SHALL have port imem_addr  out  PC_W  instruction-memory address, equal to pc.
REQ-007 SHALL have port imem_data  in  INSTR_W  instruction word, combinational read of imem_addr.
REQ-008 SHALL have port instr  out  INSTR_W  registered decode-stage instruction.
REQ-009 SHALL have port opcode  out  4  top four bits of instr, fed to the control unit.
REQ-010 SHALL have port instr_valid  out  1  instr is a real instruction; 0 = bubble.
REQ-011 SHALL have port Branch  in  1  control-unit branch request for the decode-stage instruction.
REQ-012 SHALL have port MUX7  in  2  branch kind: 0 be, 1 bne, 2 jump, 3 never taken.
REQ-013 SHALL have port zero  in  1  equality flag from the last cmp.
REQ-014 SHALL have port target  in  PC_W  absolute branch target address.
REQ-015 SHALL have port pc  out  PC_W  current fetch address.
REQ-016 SHALL have port done  out  1  program halted.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: pc=0, instr_valid=0, done=0; start -> RUN.
REQ-019 RUN, per cycle: instr<=imem_data, instr_valid<=1, decode_pc<=pc, pc<=pc+1 (mod 2^PC_W, wraps to 0).
REQ-020 First valid instr (address 0) SHALL appear one cycle after the first RUN cycle (fetch latency 1).
REQ-021 Taken = Branch & instr_valid & ((MUX7==0 & zero) | (MUX7==1 & ~zero) | MUX7==2).
REQ-022 Taken branch: pc<=target, instr_valid<=0 next cycle (wrong-path word discarded); target instr valid two cycles after the branch cycle.
REQ-023 Branch with instr_valid=0 SHALL be ignored.
REQ-024 Halt: taken jump (MUX7==2) with target==decode_pc -> DONE next cycle.
REQ-025 DONE: done=1, instr_valid=0, pc and instr held; start -> RUN with pc<=0, done<=0.
REQ-026 start in RUN SHALL be ignored.
REQ-027 opcode SHALL be forced to 0 whenever instr_valid=0 is not required; opcode always = instr top bits.

Reset
REQ-028 reset SHALL take priority over start and all other inputs.
REQ-029 On reset: state=IDLE, pc=0, decode_pc=0, instr=0, instr_valid=0, done=0.
REQ-030 reset mid-RUN SHALL abort in-flight branch; next cycle matches REQ-029.

Configuration
REQ-031 Macro INSTR_COUNT_EN defined: output instr_count (16 bits) counts cycles with instr_valid=1, saturates at 16'hFFFF, clears on reset and on start accepted in IDLE/DONE, holds in DONE.
REQ-032 INSTR_COUNT_EN undefined: instr_count port and counter absent; all other behaviour identical.

Verification
REQ-033 reset, start at cycle 0, imem[0..3]=distinct words, no branches -> pc 0,1,2,3; instr_valid=1 from cycle 2, instr matches imem[n] one cycle after pc=n.
REQ-034 be at address 2, zero=1, target=8'h10 -> pc=8'h10 next, one bubble (instr_valid=0), instr=imem[16] after; with zero=0 -> pc continues 3,4.
REQ-035 bne at address 2, zero=0, target=5 -> taken; MUX7=3 with Branch=1 -> never taken.
REQ-036 jump at address 4 with target=4 -> done=1 next cycle, instr_valid=0, pc held; start -> pc=0, done=0, execution restarts.
REQ-037 reset asserted the cycle a taken branch is decoded -> pc=0, IDLE, branch not performed; pc=8'hFF sequential -> wraps to 0.
REQ-038 INSTR_COUNT_EN: 5 valid instrs then halt -> instr_count=6 (incl. halt jump), held in DONE, cleared on restart.
